// File: rtl/sprite_row_engine.sv
// Sprite-row renderer: queued draw commands are expanded into SPR_W pixels each,
// fetched from sprite ROM and written to the line buffer with flip, colour-key and clipping.
module sprite_row_engine #(
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int FRAME_BITS = 8,
  parameter int COL_BITS   = 10,
  parameter int LINE_W     = 640,
  parameter int PIX_W      = 16,
  parameter int ROM_AW     = 16,
  parameter int QDEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [COL_BITS-1:0]      cmd_col,
  input  logic [FRAME_BITS-1:0]    cmd_frame,
  input  logic [$clog2(SPR_H)-1:0] cmd_row,
  input  logic                     cmd_hflip,
  input  logic                     cmd_vflip,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [PIX_W-1:0]         rom_q,
  output logic [COL_BITS-1:0]      pixel_col,
  output logic [PIX_W-1:0]         pixel_data,
  output logic                     wren,
  output logic                     sprite_done,
  output logic                     busy
);
  localparam int RB = $clog2(SPR_H);
  localparam int IB = $clog2(SPR_W);
  localparam int QB = $clog2(QDEPTH);
  localparam int AF = FRAME_BITS + RB + IB;
  localparam logic [QB:0]       QFULL    = (QB+1)'(QDEPTH);
  localparam logic [COL_BITS:0] LINE_LIM = (COL_BITS+1)'(LINE_W);
  localparam logic [IB-1:0]     LAST_IDX = IB'(SPR_W-1);

  typedef struct packed {
    logic [COL_BITS-1:0]   col;
    logic [FRAME_BITS-1:0] frame;
    logic [RB-1:0]         row;
    logic                  hflip;
    logic                  vflip;
  } cmd_t;

  typedef enum logic {IDLE, FETCH} state_t;

  // command FIFO
  cmd_t          fifo_mem [QDEPTH];
  logic [QB-1:0] wr_ptr, rd_ptr;
  logic [QB:0]   count;
  logic          push, pop, fifo_empty;
  cmd_t          head, in_cmd;

  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != QFULL) && !flush && !reset;
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_mem[rd_ptr];
  assign in_cmd     = '{col: cmd_col, frame: cmd_frame, row: cmd_row,
                        hflip: cmd_hflip, vflip: cmd_vflip};

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= in_cmd;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (QB+1)'(push) - (QB+1)'(pop);
    end
  end

  // fetch FSM; s1_* describe the address currently on rom_addr
  state_t                state, state_nxt;
  logic                  issue;
  logic [FRAME_BITS-1:0] s1_frame, n_frame;
  logic [RB-1:0]         s1_row_e, n_row_e;
  logic [IB-1:0]         s1_idx, n_idx;
  logic [COL_BITS-1:0]   s1_col, n_col;
  logic                  s1_hflip, n_hflip;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        issue     = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        if (s1_idx != LAST_IDX) issue = 1'b1;
        else if (!fifo_empty) begin
          pop   = 1'b1;
          issue = 1'b1;
        end else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      pop       = 1'b0;
      issue     = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_comb begin
    n_frame = s1_frame;
    n_row_e = s1_row_e;
    n_col   = s1_col;
    n_hflip = s1_hflip;
    n_idx   = s1_idx + 1'b1;
    if (pop) begin
      n_frame = head.frame;
      n_row_e = head.vflip ? RB'(SPR_H-1) - head.row : head.row;
      n_col   = head.col;
      n_hflip = head.hflip;
      n_idx   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_frame <= '0;
      s1_row_e <= '0;
      s1_idx   <= '0;
      s1_col   <= '0;
      s1_hflip <= 1'b0;
      rom_addr <= '0;
    end else if (issue) begin
      s1_frame <= n_frame;
      s1_row_e <= n_row_e;
      s1_idx   <= n_idx;
      s1_col   <= n_col;
      s1_hflip <= n_hflip;
      // power-of-2 geometry turns frame*W*H + row*W + idx into a concatenation
      rom_addr <= ROM_AW'({n_frame, n_row_e, n_idx});
    end
  end

  // pixel pipeline: [1] = ROM data cycle, [2] = output slot
  logic [2:1]          vld_pipe;
  logic [IB-1:0]       off;
  logic [COL_BITS:0]   s2_sum;
  logic                s2_last;

  assign off = s1_hflip ? LAST_IDX - s1_idx : s1_idx;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_pipe    <= '0;
      s2_sum      <= '0;
      s2_last     <= 1'b0;
      wren        <= 1'b0;
      sprite_done <= 1'b0;
      if (reset) begin
        pixel_col  <= '0;
        pixel_data <= '0;
      end
    end else begin
      vld_pipe[1] <= (state == FETCH);
      vld_pipe[2] <= vld_pipe[1];
      s2_sum      <= (COL_BITS+1)'(s1_col) + (COL_BITS+1)'(off);
      s2_last     <= (s1_idx == LAST_IDX);
      if (vld_pipe[1]) begin
        pixel_col  <= s2_sum[COL_BITS-1:0];
        pixel_data <= rom_q;
      end
      // sum kept one bit wider so columns past the line edge clip instead of wrapping
      wren        <= vld_pipe[1] && !rom_q[PIX_W-1] && (s2_sum < LINE_LIM);
      sprite_done <= vld_pipe[1] && s2_last;
    end
  end

  assign busy = !fifo_empty || (state == FETCH) || (|vld_pipe);

endmodule

// File: tb/tb_sprite_row_engine.sv
// Bench for sprite_row_engine: ROM model, per-cycle timing scoreboard and scenario tasks.
module tb_sprite_row_engine;
  localparam int SPR_W = 16, SPR_H = 16, FRAME_BITS = 8, COL_BITS = 10;
  localparam int LINE_W = 640, PIX_W = 16, ROM_AW = 16, QDEPTH = 4;

  logic                  clk, reset, flush, cmd_valid, cmd_ready;
  logic [COL_BITS-1:0]   cmd_col;
  logic [FRAME_BITS-1:0] cmd_frame;
  logic [3:0]            cmd_row;
  logic                  cmd_hflip, cmd_vflip;
  logic [ROM_AW-1:0]     rom_addr;
  logic [PIX_W-1:0]      rom_q;
  logic [COL_BITS-1:0]   pixel_col;
  logic [PIX_W-1:0]      pixel_data;
  logic                  wren, sprite_done, busy;

  sprite_row_engine #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FRAME_BITS(FRAME_BITS), .COL_BITS(COL_BITS),
    .LINE_W(LINE_W), .PIX_W(PIX_W), .ROM_AW(ROM_AW), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_col(cmd_col), .cmd_frame(cmd_frame), .cmd_row(cmd_row), .cmd_hflip(cmd_hflip),
    .cmd_vflip(cmd_vflip), .rom_addr(rom_addr), .rom_q(rom_q), .pixel_col(pixel_col),
    .pixel_data(pixel_data), .wren(wren), .sprite_done(sprite_done), .busy(busy));

  logic [15:0] rom_mem [65536];
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  bit mon_en = 1'b0;

  // reference model: each accepted command gets a pop cycle, pixel slots land at pop+3+i
  typedef struct {int e; int p; int trunc;} ent_t;
  typedef struct {logic [9:0] col; logic [15:0] data; bit wr; bit done;} slot_t;
  ent_t  ents[$];
  slot_t exp_slot[int];
  int    next_pop = 0;

  function automatic void model_accept(int e, int col, int frame, int row, bit hf, bit vf);
    int p, row_e, off, sum, addr;
    slot_t s;
    p = (e + 1 > next_pop) ? e + 1 : next_pop;
    next_pop = p + SPR_W;
    row_e = vf ? SPR_H - 1 - row : row;
    ents.push_back('{e, p, 1 << 30});
    for (int i = 0; i < SPR_W; i++) begin
      off    = hf ? SPR_W - 1 - i : i;
      sum    = col + off;
      addr   = (frame * SPR_W * SPR_H + row_e * SPR_W + i) % 65536;
      s.col  = 10'(sum);
      s.data = rom_mem[addr];
      s.wr   = !rom_mem[addr][15] && (sum < LINE_W);
      s.done = (i == SPR_W - 1);
      exp_slot[p + 3 + i] = s;
    end
  endfunction

  function automatic void model_flush(int f);
    int keys[$];
    foreach (ents[k]) if (ents[k].trunc > f) ents[k].trunc = f;
    foreach (exp_slot[k]) if (k > f) keys.push_back(k);
    foreach (keys[k]) exp_slot.delete(keys[k]);
    next_pop = 0;
  endfunction

  // scoreboard: every cycle after reset
  always begin
    int c, occ, lim_o, lim_b;
    bit bsy, rdy;
    @(negedge clk);
    #2;
    if (mon_en) begin
      c = cyc; occ = 0; bsy = 1'b0;
      foreach (ents[k]) begin
        lim_o = (ents[k].p < ents[k].trunc) ? ents[k].p : ents[k].trunc;
        lim_b = (ents[k].p + SPR_W + 2 < ents[k].trunc) ? ents[k].p + SPR_W + 2 : ents[k].trunc;
        if (ents[k].e < c && c <= lim_o) occ++;
        if (ents[k].e < c && c <= lim_b) bsy = 1'b1;
      end
      rdy = !flush && (occ < QDEPTH);
      n_checks++;
      if (cmd_ready !== rdy) begin
        n_fail++; $display("FAIL cmd_ready c=%0d: got %b want %b", c, cmd_ready, rdy);
      end
      n_checks++;
      if (busy !== bsy) begin
        n_fail++; $display("FAIL busy c=%0d: got %b want %b", c, busy, bsy);
      end
      if (exp_slot.exists(c)) begin
        n_checks++;
        if (wren !== exp_slot[c].wr || sprite_done !== exp_slot[c].done ||
            pixel_col !== exp_slot[c].col || pixel_data !== exp_slot[c].data) begin
          n_fail++;
          $display("FAIL slot c=%0d: got wr=%b dn=%b col=%0d d=%h want wr=%b dn=%b col=%0d d=%h",
                   c, wren, sprite_done, pixel_col, pixel_data, exp_slot[c].wr,
                   exp_slot[c].done, exp_slot[c].col, exp_slot[c].data);
        end
      end else begin
        n_checks++;
        if (wren !== 1'b0 || sprite_done !== 1'b0) begin
          n_fail++; $display("FAIL idle_slot c=%0d: got wr=%b dn=%b want 0 0", c, wren, sprite_done);
        end
      end
    end
  end

  task automatic step(input bit v, input int col, input int frame, input int row,
                      input bit hf, input bit vf, input bit fl, output bit acc);
    @(negedge clk);
    cmd_valid = v; cmd_col = 10'(col); cmd_frame = 8'(frame); cmd_row = 4'(row);
    cmd_hflip = hf; cmd_vflip = vf; flush = fl;
    #1;
    acc = v && cmd_ready;
    if (fl) model_flush(cyc);
    else if (acc) model_accept(cyc, col, frame, row, hf, vf);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  // mode 0 opaque, 1 odd addresses transparent, 2 random ~25% transparent
  task automatic fill_rom(input int mode);
    logic [31:0] v;
    for (int a = 0; a < 65536; a++) begin
      v = $urandom;
      case (mode)
        0: rom_mem[a] = {1'b0, v[14:0]};
        1: rom_mem[a] = {a[0], v[14:0]};
        default: rom_mem[a] = {v[17:16] == 2'b00, v[14:0]};
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_col = '0; cmd_frame = '0;
    cmd_row = '0; cmd_hflip = 1'b0; cmd_vflip = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (rom_addr !== '0 || pixel_col !== '0 || pixel_data !== '0 || wren !== 1'b0 ||
        sprite_done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got addr=%h col=%0d d=%h wr=%b dn=%b busy=%b rdy=%b want 0 0 0 0 0 0 1",
               rom_addr, pixel_col, pixel_data, wren, sprite_done, busy, cmd_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic run_one(input string nm, input int col, input int frame, input int row,
                         input bit hf, input bit vf, input int base, input int exp_wr,
                         input int exp_first, input int exp_last);
    bit acc;
    int e, idx, nwr, ndone, first_col, last_col;
    nwr = 0; ndone = 0; first_col = -1; last_col = -1;
    step(1, col, frame, row, hf, vf, 0, acc);
    e = cyc;
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL %s accept: got %b want 1", nm, acc); end
    for (int k = 0; k < 24; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, acc);
      idx = cyc - (e + 2);
      if (idx >= 0 && idx < SPR_W) begin
        n_checks++;
        if (rom_addr !== 16'(base + idx)) begin
          n_fail++; $display("FAIL %s rom_addr idx=%0d: got %h want %h", nm, idx, rom_addr, 16'(base + idx));
        end
      end
      if (wren === 1'b1) begin nwr++; if (first_col < 0) first_col = int'(pixel_col); end
      if (sprite_done === 1'b1) begin ndone++; last_col = int'(pixel_col); end
    end
    n_checks++;
    if (nwr != exp_wr) begin n_fail++; $display("FAIL %s wren_count: got %0d want %0d", nm, nwr, exp_wr); end
    n_checks++;
    if (ndone != 1 || last_col != exp_last) begin
      n_fail++; $display("FAIL %s done: got n=%0d col=%0d want n=1 col=%0d", nm, ndone, last_col, exp_last);
    end
    if (exp_first >= 0) begin
      n_checks++;
      if (first_col != exp_first) begin
        n_fail++; $display("FAIL %s first_col: got %0d want %0d", nm, first_col, exp_first);
      end
    end
  endtask

  task automatic test_single();
    fill_rom(0);
    run_one("single", 100, 2, 3, 0, 0, 'h230, 16, 100, 115);
  endtask

  task automatic test_flip();
    run_one("flip", 100, 2, 3, 1, 1, 'h2C0, 16, 115, 100);
  endtask

  task automatic test_transparent();
    fill_rom(1);
    run_one("transp", 100, 2, 3, 0, 0, 'h230, 8, 100, 115);
  endtask

  task automatic test_clip();
    fill_rom(0);
    run_one("clip630", 630, 2, 3, 0, 0, 'h230, 10, 630, 645 % 1024);
    run_one("clip1020", 1020, 2, 3, 0, 0, 'h230, 0, -1, 1035 % 1024);
  endtask

  task automatic test_back_to_back();
    bit acc, offer;
    int n_acc, k5, nwr, ndone, first_c, last_c;
    fill_rom(0);
    n_acc = 0; k5 = -10; nwr = 0; ndone = 0; first_c = -1; last_c = -1;
    for (int k = 0; k < 110; k++) begin
      offer = (n_acc < 5);
      step(offer, 20 + n_acc * 100, n_acc + 1, n_acc * 3, n_acc[0], n_acc[1], 0, acc);
      if (acc) begin n_acc++; if (n_acc == 5) k5 = k; end
      if (k == k5 + 1) begin
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b want 0", cmd_ready); end
      end
      if (wren === 1'b1) begin nwr++; if (first_c < 0) first_c = cyc; last_c = cyc; end
      if (sprite_done === 1'b1) ndone++;
    end
    n_checks++;
    if (n_acc != 5) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 5", n_acc); end
    n_checks++;
    if (nwr != 80 || last_c - first_c + 1 != 80 || ndone != 5) begin
      n_fail++;
      $display("FAIL b2b_contig: got wr=%0d span=%0d done=%0d want 80 80 5", nwr, last_c - first_c + 1, ndone);
    end
    // second burst, flushed mid-sprite with commands still queued
    for (int i = 0; i < 3; i++) step(1, 50 * i, 7, i, 0, 0, 0, acc);
    idle(20);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
    step(1, 5, 5, 5, 0, 0, 1, acc);
    idle(1);
    n_checks++;
    if (wren !== 1'b0 || sprite_done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after: got wr=%b dn=%b busy=%b rdy=%b want 0 0 0 1", wren, sprite_done, busy, cmd_ready);
    end
    idle(25);
  endtask

  task automatic test_random();
    bit acc, fl;
    int gap;
    fill_rom(2);
    for (int n = 0; n < 40; n++) begin
      fl = ($urandom_range(0, 29) == 0);
      step(!fl, $urandom_range(0, 1023), $urandom_range(0, 255), $urandom_range(0, 15),
           1'($urandom), 1'($urandom), fl, acc);
      gap = $urandom_range(0, 3);
      if (gap == 3) gap = 20;
      idle(gap);
    end
    idle(40);
  endtask

  initial begin
    test_reset();
    test_single();
    test_flip();
    test_transparent();
    test_clip();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
